msrv32_pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register for the msrv32 core. Replaces the fixed
//  7-bit stage-2 register with a valid/ready-handshaked stage of one main

---
 rtl/msrv32_pipe_pkg.sv | 22 ++
 rtl/msrv32_pipe_stage_reg_if.sv | 29 ++
 rtl/msrv32_sat_counter.sv | 21 ++
 rtl/msrv32_pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_msrv32_pipe_stage_reg.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/msrv32_pipe_pkg.sv
// rtl/msrv32_pipe_pkg.sv - shared widths, control bitfield and bubble constant for the msrv32 stage register
package msrv32_pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 16;
  localparam int PIPE_CNT_W  = 16;

  // Control word travelling with each instruction; a bubble zeroes every field.
  typedef struct packed {
    logic       rf_wr_en;
    logic       csr_wr_en;
    logic [2:0] wb_mux_sel;
    logic [2:0] csr_op;
    logic [3:0] alu_opcode;
    logic [1:0] load_size;
    logic       load_unsigned;
    logic       alu_src;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PIPE_BUBBLE = '0;

endpackage

// File: rtl/msrv32_pipe_stage_reg_if.sv
// rtl/msrv32_pipe_stage_reg_if.sv - upstream/downstream valid/ready channels of the pipeline stage
interface msrv32_pipe_stage_reg_if
  import msrv32_pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
);

  logic              up_valid_in;
  logic              up_ready_out;
  logic [DATA_W-1:0] up_data_in;
  logic [CTRL_W-1:0] up_ctrl_in;
  logic              dn_valid_out;
  logic              dn_ready_in;
  logic [DATA_W-1:0] dn_data_out;
  logic [CTRL_W-1:0] dn_ctrl_out;

  // master: the surrounding pipeline; slave: the stage register itself
  modport master (
    output up_valid_in, up_data_in, up_ctrl_in, dn_ready_in,
    input  up_ready_out, dn_valid_out, dn_data_out, dn_ctrl_out
  );

  modport slave (
    input  up_valid_in, up_data_in, up_ctrl_in, dn_ready_in,
    output up_ready_out, dn_valid_out, dn_data_out, dn_ctrl_out
  );

endinterface

// File: rtl/msrv32_sat_counter.sv
// rtl/msrv32_sat_counter.sv - saturating event counter, cleared only by reset
module msrv32_sat_counter
  import msrv32_pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             inc_in,
  output logic [CNT_W-1:0] count_out
);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count_out <= '0;
    end else if (inc_in && (count_out != {CNT_W{1'b1}})) begin
      count_out <= count_out + CNT_W'(1);
    end
  end

endmodule

// File: rtl/msrv32_pipe_stage_reg.sv
// rtl/msrv32_pipe_stage_reg.sv - handshaked pipeline stage with optional skid entry, flush bubbles and stall/flush counters
module msrv32_pipe_stage_reg
  import msrv32_pipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int CTRL_W  = PIPE_CTRL_W,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = PIPE_CNT_W
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  msrv32_pipe_stage_reg_if.slave pipe,
  input  logic                   flush_in,
  input  logic                   stall_in,
  output logic [CNT_W-1:0]       stall_cnt_out,
  output logic [CNT_W-1:0]       flush_cnt_out
);

  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(PIPE_BUBBLE);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              dn_valid;
  logic              up_ready;
  logic              dn_take;
  logic              up_take;

  assign dn_valid = m_valid & ~stall_in & ~reset_in;

  // With the skid entry, ready depends only on local state so no dn_ready_in path exists.
  if (SKID_EN) begin : g_ready_skid
    assign up_ready = ~s_valid & ~stall_in & ~reset_in;
  end else begin : g_ready_main
    assign up_ready = (~m_valid | pipe.dn_ready_in) & ~stall_in & ~reset_in;
  end

  assign dn_take = dn_valid & pipe.dn_ready_in;
  assign up_take = pipe.up_valid_in & up_ready;

  assign pipe.dn_valid_out = dn_valid;
  assign pipe.up_ready_out = up_ready;
  assign pipe.dn_data_out  = m_data;
  assign pipe.dn_ctrl_out  = dn_valid ? m_ctrl : BUBBLE;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
    end else if (flush_in) begin
      m_valid <= 1'b0;
      m_ctrl  <= BUBBLE;
    end else if (dn_take) begin
      if (s_valid) begin
        m_data <= s_data;
        m_ctrl <= s_ctrl;
      end else if (up_take) begin
        m_data <= pipe.up_data_in;
        m_ctrl <= pipe.up_ctrl_in;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (up_take && !m_valid) begin
      m_valid <= 1'b1;
      m_data  <= pipe.up_data_in;
      m_ctrl  <= pipe.up_ctrl_in;
    end
  end

  // Skid only fills when main is held, so it is always the younger entry.
  if (SKID_EN) begin : g_skid
    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        s_valid <= 1'b0;
        s_data  <= '0;
        s_ctrl  <= '0;
      end else if (flush_in) begin
        s_valid <= 1'b0;
        s_ctrl  <= BUBBLE;
      end else if (dn_take && s_valid) begin
        s_valid <= 1'b0;
      end else if (!dn_take && up_take && m_valid) begin
        s_valid <= 1'b1;
        s_data  <= pipe.up_data_in;
        s_ctrl  <= pipe.up_ctrl_in;
      end
    end
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_data  = '0;
    assign s_ctrl  = '0;
  end

  msrv32_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .inc_in    (stall_in & ~flush_in),
    .count_out (stall_cnt_out)
  );

  msrv32_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .inc_in    (flush_in),
    .count_out (flush_cnt_out)
  );

endmodule

// File: tb/tb_msrv32_pipe_stage_reg.sv
// tb/tb_msrv32_pipe_stage_reg.sv - bench for the stage register: skid/16-bit and no-skid/4-bit instances against a FIFO model
module tb_msrv32_pipe_stage_reg;
  import msrv32_pipe_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] c;
  } ent_t;

  logic clk_in = 1'b0;
  logic reset_in, flush_in, stall_in;
  logic [15:0] sca, fca;
  logic [3:0]  scb, fcb;

  always #5 clk_in = ~clk_in;

  msrv32_pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) ia ();
  msrv32_pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) ib ();

  msrv32_pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1'b1), .CNT_W(16)) dut_a (
    .clk_in(clk_in), .reset_in(reset_in), .pipe(ia), .flush_in(flush_in),
    .stall_in(stall_in), .stall_cnt_out(sca), .flush_cnt_out(fca)
  );

  msrv32_pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1'b0), .CNT_W(4)) dut_b (
    .clk_in(clk_in), .reset_in(reset_in), .pipe(ib), .flush_in(flush_in),
    .stall_in(stall_in), .stall_cnt_out(scb), .flush_cnt_out(fcb)
  );

  // Reference: each instance is an in-order FIFO of capacity cap[k] plus two saturating tallies.
  ent_t fifo [2][2];
  int   occ  [2] = '{0, 0};
  int   sc   [2] = '{0, 0};
  int   fc   [2] = '{0, 0};
  int   cap  [2] = '{2, 1};
  int   cmax [2] = '{65535, 15};
  bit   exp_v[2];
  bit   exp_r[2];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_k(input int k, input bit dr);
    logic ov, orr;
    logic [31:0] od;
    logic [15:0] oc, os, of;
    string p;
    bit ev, er;
    if (k == 0) begin
      p = "a"; ov = ia.dn_valid_out; orr = ia.up_ready_out; od = ia.dn_data_out;
      oc = ia.dn_ctrl_out; os = sca; of = fca;
    end else begin
      p = "b"; ov = ib.dn_valid_out; orr = ib.up_ready_out; od = ib.dn_data_out;
      oc = ib.dn_ctrl_out; os = {12'b0, scb}; of = {12'b0, fcb};
    end
    ev = (occ[k] > 0) && !stall_in && !reset_in;
    er = !stall_in && !reset_in && ((cap[k] == 2) ? (occ[k] < 2) : (occ[k] == 0 || dr));
    exp_v[k] = ev;
    exp_r[k] = er;
    chk({p, "_dn_valid"}, {31'b0, ov}, {31'b0, ev});
    chk({p, "_up_ready"}, {31'b0, orr}, {31'b0, er});
    chk({p, "_dn_ctrl"}, {16'b0, oc}, ev ? {16'b0, fifo[k][0].c} : 32'h0);
    if (ev) chk({p, "_dn_data"}, od, fifo[k][0].d);
    chk({p, "_stall_cnt"}, {16'b0, os}, sc[k]);
    chk({p, "_flush_cnt"}, {16'b0, of}, fc[k]);
  endtask

  task automatic upd(input int k, input bit uv, input ent_t e, input bit dr);
    if (reset_in) begin
      occ[k] = 0; sc[k] = 0; fc[k] = 0;
    end else if (flush_in) begin
      occ[k] = 0;
      if (fc[k] < cmax[k]) fc[k]++;
    end else if (stall_in) begin
      if (sc[k] < cmax[k]) sc[k]++;
    end else begin
      if (exp_v[k] && dr) begin
        fifo[k][0] = fifo[k][1];
        occ[k]--;
      end
      if (uv && exp_r[k]) begin
        fifo[k][occ[k]] = e;
        occ[k]++;
      end
    end
  endtask

  task automatic cyc(input bit uv, input logic [31:0] d, input logic [15:0] c,
                     input bit dr, input bit fl, input bit st, input bit rs);
    ent_t e;
    e.d = d;
    e.c = c;
    ia.up_valid_in = uv; ia.up_data_in = d; ia.up_ctrl_in = c; ia.dn_ready_in = dr;
    ib.up_valid_in = uv; ib.up_data_in = d; ib.up_ctrl_in = c; ib.dn_ready_in = dr;
    flush_in = fl; stall_in = st; reset_in = rs;
    @(negedge clk_in);
    for (int k = 0; k < 2; k++) check_k(k, dr);
    @(posedge clk_in);
    for (int k = 0; k < 2; k++) upd(k, uv, e, dr);
    #1;
  endtask

  initial begin
    // 1: reset then back-to-back stream
    cyc(0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    chk("a_data_reset", ia.dn_data_out, 32'h0);
    cyc(1, 32'h100, 16'h0011, 1, 0, 0, 0);
    cyc(1, 32'h104, 16'h0022, 1, 0, 0, 0);
    cyc(1, 32'h108, 16'h0033, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // 2: backpressure into the skid entry, then release
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h100, 16'h0101, 0, 0, 0, 0);
    cyc(1, 32'h104, 16'h0102, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // 3: flush a full stage while upstream offers a wrong-path instruction
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h200, 16'h0FFF, 0, 0, 0, 0);
    cyc(1, 32'h204, 16'h0FFF, 0, 0, 0, 0);
    cyc(1, 32'h208, 16'h0FFF, 0, 1, 0, 0);
    chk("s3_flush_cnt", {16'b0, fca}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // 4: stall three cycles with an instruction held
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h300, 16'h0123, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    chk("s4_stall_cnt", {16'b0, sca}, 32'd3);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // 5: flush+stall together, then reset with an instruction held
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h400, 16'h0456, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("s5_stall_cnt", {16'b0, sca}, 32'd0);
    chk("s5_flush_cnt", {16'b0, fca}, 32'd1);
    cyc(1, 32'h404, 16'h0789, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("s5_a_data", ia.dn_data_out, 32'h0);
    chk("s5_b_data", ib.dn_data_out, 32'h0);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // 6: counter saturation, then backpressure rerun where ready tracks dn_ready on the no-skid stage
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0, 1, 0);
    chk("s6_a_stall_cnt", {16'b0, sca}, 32'd20);
    chk("s6_b_stall_cnt", {28'b0, scb}, 32'd15);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h100, 16'h0201, 0, 0, 0, 0);
    cyc(1, 32'h104, 16'h0202, 0, 0, 0, 0);
    cyc(1, 32'h104, 16'h0202, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // Random traffic with occasional flush, stall and reset
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 16'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
